// File: rtl/tl_acquire_arbiter_2to1_if.sv
// rtl/tl_acquire_arbiter_2to1_if.sv - client, manager and status signals of the 2:1 acquire arbiter
interface tl_acquire_arbiter_2to1_if;
    // client 0 acquire / grant
    logic        io_c0_acquire_ready;
    logic        io_c0_acquire_valid;
    logic [25:0] io_c0_acquire_bits_addr_block;
    logic [0:0]  io_c0_acquire_bits_client_xact_id;
    logic [2:0]  io_c0_acquire_bits_addr_beat;
    logic        io_c0_acquire_bits_is_builtin_type;
    logic [2:0]  io_c0_acquire_bits_a_type;
    logic [11:0] io_c0_acquire_bits_union;
    logic [63:0] io_c0_acquire_bits_data;
    logic        io_c0_grant_ready;
    logic        io_c0_grant_valid;
    logic [2:0]  io_c0_grant_bits_addr_beat;
    logic [0:0]  io_c0_grant_bits_client_xact_id;
    logic [1:0]  io_c0_grant_bits_manager_xact_id;
    logic        io_c0_grant_bits_is_builtin_type;
    logic [3:0]  io_c0_grant_bits_g_type;
    logic [63:0] io_c0_grant_bits_data;
    // client 1 acquire / grant
    logic        io_c1_acquire_ready;
    logic        io_c1_acquire_valid;
    logic [25:0] io_c1_acquire_bits_addr_block;
    logic [0:0]  io_c1_acquire_bits_client_xact_id;
    logic [2:0]  io_c1_acquire_bits_addr_beat;
    logic        io_c1_acquire_bits_is_builtin_type;
    logic [2:0]  io_c1_acquire_bits_a_type;
    logic [11:0] io_c1_acquire_bits_union;
    logic [63:0] io_c1_acquire_bits_data;
    logic        io_c1_grant_ready;
    logic        io_c1_grant_valid;
    logic [2:0]  io_c1_grant_bits_addr_beat;
    logic [0:0]  io_c1_grant_bits_client_xact_id;
    logic [1:0]  io_c1_grant_bits_manager_xact_id;
    logic        io_c1_grant_bits_is_builtin_type;
    logic [3:0]  io_c1_grant_bits_g_type;
    logic [63:0] io_c1_grant_bits_data;
    // shared manager port
    logic        io_out_acquire_ready;
    logic        io_out_acquire_valid;
    logic [25:0] io_out_acquire_bits_addr_block;
    logic [0:0]  io_out_acquire_bits_client_xact_id;
    logic [2:0]  io_out_acquire_bits_addr_beat;
    logic        io_out_acquire_bits_is_builtin_type;
    logic [2:0]  io_out_acquire_bits_a_type;
    logic [11:0] io_out_acquire_bits_union;
    logic [63:0] io_out_acquire_bits_data;
    logic        io_out_acquire_bits_client_id;
    logic        io_out_grant_ready;
    logic        io_out_grant_valid;
    logic [2:0]  io_out_grant_bits_addr_beat;
    logic [0:0]  io_out_grant_bits_client_xact_id;
    logic [1:0]  io_out_grant_bits_manager_xact_id;
    logic        io_out_grant_bits_is_builtin_type;
    logic [3:0]  io_out_grant_bits_g_type;
    logic [63:0] io_out_grant_bits_data;
    logic        io_out_grant_bits_client_id;
    logic        io_busy;

    // arbiter view
    modport master (
        output io_c0_acquire_ready,
        input  io_c0_acquire_valid, io_c0_acquire_bits_addr_block, io_c0_acquire_bits_client_xact_id,
               io_c0_acquire_bits_addr_beat, io_c0_acquire_bits_is_builtin_type, io_c0_acquire_bits_a_type,
               io_c0_acquire_bits_union, io_c0_acquire_bits_data, io_c0_grant_ready,
        output io_c0_grant_valid, io_c0_grant_bits_addr_beat, io_c0_grant_bits_client_xact_id,
               io_c0_grant_bits_manager_xact_id, io_c0_grant_bits_is_builtin_type, io_c0_grant_bits_g_type,
               io_c0_grant_bits_data,
        output io_c1_acquire_ready,
        input  io_c1_acquire_valid, io_c1_acquire_bits_addr_block, io_c1_acquire_bits_client_xact_id,
               io_c1_acquire_bits_addr_beat, io_c1_acquire_bits_is_builtin_type, io_c1_acquire_bits_a_type,
               io_c1_acquire_bits_union, io_c1_acquire_bits_data, io_c1_grant_ready,
        output io_c1_grant_valid, io_c1_grant_bits_addr_beat, io_c1_grant_bits_client_xact_id,
               io_c1_grant_bits_manager_xact_id, io_c1_grant_bits_is_builtin_type, io_c1_grant_bits_g_type,
               io_c1_grant_bits_data,
        input  io_out_acquire_ready,
        output io_out_acquire_valid, io_out_acquire_bits_addr_block, io_out_acquire_bits_client_xact_id,
               io_out_acquire_bits_addr_beat, io_out_acquire_bits_is_builtin_type, io_out_acquire_bits_a_type,
               io_out_acquire_bits_union, io_out_acquire_bits_data, io_out_acquire_bits_client_id,
               io_out_grant_ready,
        input  io_out_grant_valid, io_out_grant_bits_addr_beat, io_out_grant_bits_client_xact_id,
               io_out_grant_bits_manager_xact_id, io_out_grant_bits_is_builtin_type, io_out_grant_bits_g_type,
               io_out_grant_bits_data, io_out_grant_bits_client_id,
        output io_busy
    );

    // environment view (clients and manager)
    modport slave (
        input  io_c0_acquire_ready,
        output io_c0_acquire_valid, io_c0_acquire_bits_addr_block, io_c0_acquire_bits_client_xact_id,
               io_c0_acquire_bits_addr_beat, io_c0_acquire_bits_is_builtin_type, io_c0_acquire_bits_a_type,
               io_c0_acquire_bits_union, io_c0_acquire_bits_data, io_c0_grant_ready,
        input  io_c0_grant_valid, io_c0_grant_bits_addr_beat, io_c0_grant_bits_client_xact_id,
               io_c0_grant_bits_manager_xact_id, io_c0_grant_bits_is_builtin_type, io_c0_grant_bits_g_type,
               io_c0_grant_bits_data,
        input  io_c1_acquire_ready,
        output io_c1_acquire_valid, io_c1_acquire_bits_addr_block, io_c1_acquire_bits_client_xact_id,
               io_c1_acquire_bits_addr_beat, io_c1_acquire_bits_is_builtin_type, io_c1_acquire_bits_a_type,
               io_c1_acquire_bits_union, io_c1_acquire_bits_data, io_c1_grant_ready,
        input  io_c1_grant_valid, io_c1_grant_bits_addr_beat, io_c1_grant_bits_client_xact_id,
               io_c1_grant_bits_manager_xact_id, io_c1_grant_bits_is_builtin_type, io_c1_grant_bits_g_type,
               io_c1_grant_bits_data,
        output io_out_acquire_ready,
        input  io_out_acquire_valid, io_out_acquire_bits_addr_block, io_out_acquire_bits_client_xact_id,
               io_out_acquire_bits_addr_beat, io_out_acquire_bits_is_builtin_type, io_out_acquire_bits_a_type,
               io_out_acquire_bits_union, io_out_acquire_bits_data, io_out_acquire_bits_client_id,
               io_out_grant_ready,
        output io_out_grant_valid, io_out_grant_bits_addr_beat, io_out_grant_bits_client_xact_id,
               io_out_grant_bits_manager_xact_id, io_out_grant_bits_is_builtin_type, io_out_grant_bits_g_type,
               io_out_grant_bits_data, io_out_grant_bits_client_id,
        input  io_busy
    );
endinterface

// File: rtl/tl_acquire_arbiter_2to1.sv
// rtl/tl_acquire_arbiter_2to1.sv - round-robin 2:1 TileLink acquire arbiter with PutBlock locking and grant routing
module tl_acquire_arbiter_2to1 #(
    parameter int BEATS   = 8,
    parameter int MAX_OUT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    tl_acquire_arbiter_2to1_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);
    localparam logic [1:0] CNT_MAX   = 2'(MAX_OUT);

    state_e     state_q, state_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [2:0] beat_cnt_q, beat_cnt_d;
    logic [1:0] out_cnt0_q, out_cnt0_d;
    logic [1:0] out_cnt1_q, out_cnt1_d;

    logic elig0, elig1, sel, any_sel, acc, is_put, inc0, inc1;
    logic g_sel, g_multi, g_done, dec0, dec1;

    // pick the client that owns the manager port this cycle (lock overrides round robin)
    always_comb begin
        elig0   = bus.io_c0_acquire_valid && ((out_cnt0_q < CNT_MAX) || (state_q == LOCK0));
        elig1   = bus.io_c1_acquire_valid && ((out_cnt1_q < CNT_MAX) || (state_q == LOCK1));
        sel     = 1'b0;
        any_sel = 1'b0;
        case (state_q)
            LOCK0: begin
                sel     = 1'b0;
                any_sel = bus.io_c0_acquire_valid;
            end
            LOCK1: begin
                sel     = 1'b1;
                any_sel = bus.io_c1_acquire_valid;
            end
            default: begin
                any_sel = elig0 || elig1;
                sel     = (elig0 && elig1) ? rr_ptr_q : elig1;
            end
        endcase
    end

    assign bus.io_out_acquire_valid               = reset && any_sel;
    assign bus.io_out_acquire_bits_client_id      = sel;
    assign bus.io_out_acquire_bits_addr_block     = sel ? bus.io_c1_acquire_bits_addr_block     : bus.io_c0_acquire_bits_addr_block;
    assign bus.io_out_acquire_bits_client_xact_id = sel ? bus.io_c1_acquire_bits_client_xact_id : bus.io_c0_acquire_bits_client_xact_id;
    assign bus.io_out_acquire_bits_addr_beat      = sel ? bus.io_c1_acquire_bits_addr_beat      : bus.io_c0_acquire_bits_addr_beat;
    assign bus.io_out_acquire_bits_is_builtin_type = sel ? bus.io_c1_acquire_bits_is_builtin_type : bus.io_c0_acquire_bits_is_builtin_type;
    assign bus.io_out_acquire_bits_a_type         = sel ? bus.io_c1_acquire_bits_a_type         : bus.io_c0_acquire_bits_a_type;
    assign bus.io_out_acquire_bits_union          = sel ? bus.io_c1_acquire_bits_union          : bus.io_c0_acquire_bits_union;
    assign bus.io_out_acquire_bits_data           = sel ? bus.io_c1_acquire_bits_data           : bus.io_c0_acquire_bits_data;

    // a client that is ineligible is never selected, so ready is qualified by any_sel
    assign bus.io_c0_acquire_ready = reset && any_sel && !sel && bus.io_out_acquire_ready;
    assign bus.io_c1_acquire_ready = reset && any_sel &&  sel && bus.io_out_acquire_ready;

    assign acc    = bus.io_out_acquire_valid && bus.io_out_acquire_ready;
    assign is_put = bus.io_out_acquire_bits_is_builtin_type && (bus.io_out_acquire_bits_a_type == 3'h3);

    // grant demux: bits fan out to both clients, valid/ready follow client_id
    assign g_sel                             = bus.io_out_grant_bits_client_id;
    assign bus.io_c0_grant_valid             = reset && bus.io_out_grant_valid && !g_sel;
    assign bus.io_c1_grant_valid             = reset && bus.io_out_grant_valid &&  g_sel;
    assign bus.io_out_grant_ready            = reset && (g_sel ? bus.io_c1_grant_ready : bus.io_c0_grant_ready);
    assign bus.io_c0_grant_bits_addr_beat       = bus.io_out_grant_bits_addr_beat;
    assign bus.io_c0_grant_bits_client_xact_id  = bus.io_out_grant_bits_client_xact_id;
    assign bus.io_c0_grant_bits_manager_xact_id = bus.io_out_grant_bits_manager_xact_id;
    assign bus.io_c0_grant_bits_is_builtin_type = bus.io_out_grant_bits_is_builtin_type;
    assign bus.io_c0_grant_bits_g_type          = bus.io_out_grant_bits_g_type;
    assign bus.io_c0_grant_bits_data            = bus.io_out_grant_bits_data;
    assign bus.io_c1_grant_bits_addr_beat       = bus.io_out_grant_bits_addr_beat;
    assign bus.io_c1_grant_bits_client_xact_id  = bus.io_out_grant_bits_client_xact_id;
    assign bus.io_c1_grant_bits_manager_xact_id = bus.io_out_grant_bits_manager_xact_id;
    assign bus.io_c1_grant_bits_is_builtin_type = bus.io_out_grant_bits_is_builtin_type;
    assign bus.io_c1_grant_bits_g_type          = bus.io_out_grant_bits_g_type;
    assign bus.io_c1_grant_bits_data            = bus.io_out_grant_bits_data;

    // only GetDataBlock grants span a block; everything else completes on its single beat
    assign g_multi = bus.io_out_grant_bits_is_builtin_type && (bus.io_out_grant_bits_g_type == 4'h5);
    assign g_done  = bus.io_out_grant_valid && bus.io_out_grant_ready &&
                     (!g_multi || (bus.io_out_grant_bits_addr_beat == LAST_BEAT));
    assign dec0    = g_done && !g_sel && (out_cnt0_q != 2'd0);
    assign dec1    = g_done &&  g_sel && (out_cnt1_q != 2'd0);

    // lock FSM, round-robin pointer and first-beat accounting
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        inc0       = 1'b0;
        inc1       = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    rr_ptr_d = ~sel;
                    inc0     = !sel;
                    inc1     = sel;
                    if (is_put) begin
                        state_d    = sel ? LOCK1 : LOCK0;
                        beat_cnt_d = 3'd1;
                    end
                end
            end
            LOCK0, LOCK1: begin
                if (acc) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = IDLE;
                        beat_cnt_d = 3'd0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        out_cnt0_d = out_cnt0_q + {1'b0, inc0} - {1'b0, dec0};
        out_cnt1_d = out_cnt1_q + {1'b0, inc1} - {1'b0, dec1};
    end

    // state registers; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            beat_cnt_q <= 3'd0;
            out_cnt0_q <= 2'd0;
            out_cnt1_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            out_cnt0_q <= out_cnt0_d;
            out_cnt1_q <= out_cnt1_d;
        end
    end

    assign bus.io_busy = (state_q != IDLE) || (out_cnt0_q != 2'd0) || (out_cnt1_q != 2'd0);
endmodule
